// File: rtl/decode_stage_fwd_if.sv
// Decode-stage bus: fetch-side handshake, execute-side decoded fields,
// downstream hazard/forwarding taps and register-file read port.
// The format code is carried as a plain 3-bit vector so this file has no
// package dependency: R=0 I=1 S=2 B=3 U=4 J=5 NO_TYPE=6.
interface decode_stage_fwd_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 3
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [XLEN-1:0]            in_pc;

  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_pc;
  logic                       out_illegal;
  logic [6:0]                 out_opcode;
  logic [2:0]                 out_instr_format;
  logic [2:0]                 out_funct3;
  logic [6:0]                 out_funct7;
  logic [4:0]                 out_rs1;
  logic [4:0]                 out_rs2;
  logic [4:0]                 out_rd;
  logic [XLEN-1:0]            out_imm;
  logic [XLEN-1:0]            out_rs1_data;
  logic [XLEN-1:0]            out_rs2_data;

  logic [5*NUM_STAGES-1:0]    haz_rd;
  logic [NUM_STAGES-1:0]      haz_wr_en;
  logic [NUM_STAGES-1:0]      haz_data_valid;
  logic [XLEN*NUM_STAGES-1:0] haz_data;

  logic [4:0]                 reg_rd0;
  logic [4:0]                 reg_rd1;
  logic [XLEN-1:0]            reg_rd0_data;
  logic [XLEN-1:0]            reg_rd1_data;

  // Decode stage side
  modport master (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    input  haz_rd, haz_wr_en, haz_data_valid, haz_data,
    input  reg_rd0_data, reg_rd1_data,
    output in_ready, out_valid, out_pc, out_illegal, out_opcode, out_instr_format,
    output out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm,
    output out_rs1_data, out_rs2_data, reg_rd0, reg_rd1
  );

  // Surrounding pipeline side
  modport slave (
    output flush, in_valid, in_instr, in_pc, out_ready,
    output haz_rd, haz_wr_en, haz_data_valid, haz_data,
    output reg_rd0_data, reg_rd1_data,
    input  in_ready, out_valid, out_pc, out_illegal, out_opcode, out_instr_format,
    input  out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm,
    input  out_rs1_data, out_rs2_data, reg_rd0, reg_rd1
  );
endinterface

// File: rtl/decode_stage_fwd.sv
// RV32I decode pipeline stage with valid/ready handshake, flush and operand
// forwarding from NUM_STAGES downstream stages (index 0 = youngest).
module decode_stage_fwd #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned FWD_EN     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_stage_fwd_if.master dif
);

  typedef enum logic [2:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    S_TYPE  = 3'd2,
    B_TYPE  = 3'd3,
    U_TYPE  = 3'd4,
    J_TYPE  = 3'd5,
    NO_TYPE = 3'd6
  } instr_format_t;

  logic [31:0]        instr;
  instr_format_t      fmt;
  logic               uses_rs1, uses_rs2, has_rd;
  logic [4:0]         rs1, rs2, rd;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm;
  logic [XLEN:0]      rs1_res, rs2_res;
  logic               stall, accept;

  assign instr = dif.in_instr;

  // Returns {unresolved, value}. Walks oldest to youngest so the youngest
  // matching stage overrides; an older ready result never masks a younger
  // stage that has not produced its value yet.
  function automatic logic [XLEN:0] resolve(
    input logic [4:0]                 src,
    input logic [XLEN-1:0]            rf_data,
    input logic [5*NUM_STAGES-1:0]    hrd,
    input logic [NUM_STAGES-1:0]      hwe,
    input logic [NUM_STAGES-1:0]      hdv,
    input logic [XLEN*NUM_STAGES-1:0] hdata
  );
    logic [XLEN-1:0] val;
    logic            unres;
    val   = rf_data;
    unres = 1'b0;
    for (int unsigned k = NUM_STAGES; k > 0; k--) begin
      if (src != 5'd0 && hwe[k-1] && hrd[5*(k-1) +: 5] == src) begin
        val   = hdata[XLEN*(k-1) +: XLEN];
        unres = !(FWD_EN != 0 && hdv[k-1]);
      end
    end
    return {unres, val};
  endfunction

  // Opcode to instruction format
  always_comb begin
    fmt = NO_TYPE;
    case (instr[6:0])
      7'b0110011:                                         fmt = R_TYPE;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0001111:                                         fmt = I_TYPE;
      7'b0100011:                                         fmt = S_TYPE;
      7'b1100011:                                         fmt = B_TYPE;
      7'b0110111, 7'b0010111:                             fmt = U_TYPE;
      7'b1101111:                                         fmt = J_TYPE;
      default:                                            fmt = NO_TYPE;
    endcase
  end

  // Register fields, masked to zero when the format does not use them
  always_comb begin
    uses_rs1 = fmt inside {R_TYPE, I_TYPE, S_TYPE, B_TYPE};
    uses_rs2 = fmt inside {R_TYPE, S_TYPE, B_TYPE};
    has_rd   = fmt inside {R_TYPE, I_TYPE, U_TYPE, J_TYPE};
    rs1      = uses_rs1 ? instr[19:15] : 5'd0;
    rs2      = uses_rs2 ? instr[24:20] : 5'd0;
    rd       = has_rd   ? instr[11:7]  : 5'd0;
  end

  // Immediate assembly; the signed 32-bit value is sign-extended to XLEN
  always_comb begin
    imm32 = '0;
    case (fmt)
      I_TYPE:  imm32 = {{20{instr[31]}}, instr[31:20]};
      S_TYPE:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      U_TYPE:  imm32 = {instr[31:12], 12'd0};
      J_TYPE:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm = XLEN'(imm32);
  end

  assign dif.reg_rd0 = rs1;
  assign dif.reg_rd1 = rs2;

  // Operand selection, stall and handshake
  always_comb begin
    rs1_res      = resolve(rs1, dif.reg_rd0_data, dif.haz_rd, dif.haz_wr_en,
                           dif.haz_data_valid, dif.haz_data);
    rs2_res      = resolve(rs2, dif.reg_rd1_data, dif.haz_rd, dif.haz_wr_en,
                           dif.haz_data_valid, dif.haz_data);
    stall        = dif.in_valid && (rs1_res[XLEN] || rs2_res[XLEN]);
    dif.in_ready = !dif.flush && !stall && (!dif.out_valid || dif.out_ready);
    accept       = dif.in_valid && dif.in_ready;
  end

  // Output register: load on accept, drop valid on consume/flush, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dif.out_valid        <= 1'b0;
      dif.out_pc           <= '0;
      dif.out_illegal      <= 1'b0;
      dif.out_opcode       <= '0;
      dif.out_instr_format <= NO_TYPE;
      dif.out_funct3       <= '0;
      dif.out_funct7       <= '0;
      dif.out_rs1          <= '0;
      dif.out_rs2          <= '0;
      dif.out_rd           <= '0;
      dif.out_imm          <= '0;
      dif.out_rs1_data     <= '0;
      dif.out_rs2_data     <= '0;
    end else if (accept) begin
      dif.out_valid        <= 1'b1;
      dif.out_pc           <= dif.in_pc;
      dif.out_illegal      <= (fmt == NO_TYPE);
      dif.out_opcode       <= instr[6:0];
      dif.out_instr_format <= fmt;
      dif.out_funct3       <= instr[14:12];
      dif.out_funct7       <= instr[31:25];
      dif.out_rs1          <= rs1;
      dif.out_rs2          <= rs2;
      dif.out_rd           <= rd;
      dif.out_imm          <= imm;
      dif.out_rs1_data     <= rs1_res[XLEN-1:0];
      dif.out_rs2_data     <= rs2_res[XLEN-1:0];
    end else if (dif.flush || dif.out_ready) begin
      dif.out_valid        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Bench for decode_stage_fwd: vector table through a scoreboard queue, then
// hand sequences for backpressure, flush and asynchronous reset. A second
// instance in stall-only mode shares the inputs to check its in_ready.
module tb_decode_stage_fwd;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_NO = 3'd6;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [14:0] hrd;
    logic [2:0]  hwe;
    logic [2:0]  hdv;
    logic [95:0] hdata;
    logic        rdy;
    logic        rdy_nf;
    logic [2:0]  fmt;
    logic        ill;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[9];
  vec_t sb[$];
  vec_t e, v;

  always #5 clk = ~clk;

  decode_stage_fwd_if #(.XLEN(32), .NUM_STAGES(3)) dif ();
  decode_stage_fwd_if #(.XLEN(32), .NUM_STAGES(3)) dif0 ();

  decode_stage_fwd #(.XLEN(32), .NUM_STAGES(3), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .dif(dif.master));
  decode_stage_fwd #(.XLEN(32), .NUM_STAGES(3), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .dif(dif0.master));

  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'hA000_0000 | 32'(a));
  endfunction

  assign dif.reg_rd0_data   = rf(dif.reg_rd0);
  assign dif.reg_rd1_data   = rf(dif.reg_rd1);
  assign dif0.reg_rd0_data  = rf(dif0.reg_rd0);
  assign dif0.reg_rd1_data  = rf(dif0.reg_rd1);
  assign dif0.flush          = dif.flush;
  assign dif0.in_valid       = dif.in_valid;
  assign dif0.in_instr       = dif.in_instr;
  assign dif0.in_pc          = dif.in_pc;
  assign dif0.out_ready      = dif.out_ready;
  assign dif0.haz_rd         = dif.haz_rd;
  assign dif0.haz_wr_en      = dif.haz_wr_en;
  assign dif0.haz_data_valid = dif.haz_data_valid;
  assign dif0.haz_data       = dif.haz_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    dif.in_instr       = x.instr;
    dif.in_pc          = x.pc;
    dif.haz_rd         = x.hrd;
    dif.haz_wr_en      = x.hwe;
    dif.haz_data_valid = x.hdv;
    dif.haz_data       = x.hdata;
  endtask

  task automatic check_out(input string tag, input vec_t x);
    chk({tag, ".valid"},   64'(dif.out_valid), 64'd1);
    chk({tag, ".pc"},      64'(dif.out_pc), 64'(x.pc));
    chk({tag, ".fmt"},     64'(dif.out_instr_format), 64'(x.fmt));
    chk({tag, ".illegal"}, 64'(dif.out_illegal), 64'(x.ill));
    chk({tag, ".opcode"},  64'(dif.out_opcode), 64'(x.op));
    chk({tag, ".funct3"},  64'(dif.out_funct3), 64'(x.f3));
    chk({tag, ".funct7"},  64'(dif.out_funct7), 64'(x.f7));
    chk({tag, ".rd"},      64'(dif.out_rd), 64'(x.rd));
    chk({tag, ".rs1"},     64'(dif.out_rs1), 64'(x.rs1));
    chk({tag, ".rs2"},     64'(dif.out_rs2), 64'(x.rs2));
    chk({tag, ".imm"},     64'(dif.out_imm), 64'(x.imm));
    chk({tag, ".rs1_data"}, 64'(dif.out_rs1_data), 64'(x.d1));
    chk({tag, ".rs2_data"}, 64'(dif.out_rs2_data), 64'(x.d2));
  endtask

  initial begin
    // instr, pc, haz_rd{s2,s1,s0}, wr_en, data_valid, haz_data{s2,s1,s0},
    // ready, ready_nofwd, fmt, illegal, opcode, f3, f7, rd, rs1, rs2, imm, rs1_data, rs2_data
    // addi x5,x0,-1: x0 and unused rs2 field never hazard
    tbl[0] = '{32'hFFF00293, 32'h100, {5'd0, 5'd31, 5'd0}, 3'b011, 3'b000, 96'd0,
               1'b1, 1'b1, F_I, 1'b0, 7'h13, 3'd0, 7'h7F, 5'd5, 5'd0, 5'd0,
               32'hFFFF_FFFF, 32'd0, 32'd0};
    // add x3,x1,x2 with x1 forwarded from stage 0
    tbl[1] = '{32'h002081B3, 32'h104, {5'd0, 5'd0, 5'd1}, 3'b001, 3'b001,
               {32'd0, 32'd0, 32'h1234},
               1'b1, 1'b0, F_R, 1'b0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,
               32'd0, 32'h1234, 32'hA000_0002};
    // stage 0 pending on x1, stage 2 ready on x1: must stall
    tbl[2] = '{32'h002081B3, 32'h108, {5'd1, 5'd0, 5'd1}, 3'b101, 3'b100,
               {32'h5555, 32'd0, 32'h1234},
               1'b0, 1'b0, F_R, 1'b0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,
               32'd0, 32'h1234, 32'hA000_0002};
    // stage 0 resolves: youngest value wins
    tbl[3] = '{32'h002081B3, 32'h108, {5'd1, 5'd0, 5'd1}, 3'b101, 3'b101,
               {32'h5555, 32'd0, 32'h1234},
               1'b1, 1'b0, F_R, 1'b0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,
               32'd0, 32'h1234, 32'hA000_0002};
    // sw x2,8(x1): rs2 from stage 1 over stage 2
    tbl[4] = '{32'h0020A423, 32'h10C, {5'd2, 5'd2, 5'd0}, 3'b110, 3'b110,
               {32'hDEAD, 32'hBEEF, 32'd0},
               1'b1, 1'b0, F_S, 1'b0, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2,
               32'd8, 32'hA000_0001, 32'hBEEF};
    // beq x1,x2,-4
    tbl[5] = '{32'hFE208EE3, 32'h110, 15'd0, 3'b000, 3'b000, 96'd0,
               1'b1, 1'b1, F_B, 1'b0, 7'h63, 3'd0, 7'h7F, 5'd0, 5'd1, 5'd2,
               32'hFFFF_FFFC, 32'hA000_0001, 32'hA000_0002};
    // lui x7,0x12345: pending write to its rs1 field (x8) is ignored
    tbl[6] = '{32'h123453B7, 32'h114, {5'd0, 5'd0, 5'd8}, 3'b001, 3'b000, 96'd0,
               1'b1, 1'b1, F_U, 1'b0, 7'h37, 3'd5, 7'h09, 5'd7, 5'd0, 5'd0,
               32'h1234_5000, 32'd0, 32'd0};
    // jal x1,-8
    tbl[7] = '{32'hFF9FF0EF, 32'h118, 15'd0, 3'b000, 3'b000, 96'd0,
               1'b1, 1'b1, F_J, 1'b0, 7'h6F, 3'd7, 7'h7F, 5'd1, 5'd0, 5'd0,
               32'hFFFF_FFF8, 32'd0, 32'd0};
    // opcode 0x7F with rd field 31: illegal, rd/imm forced to 0
    tbl[8] = '{32'h00000FFF, 32'h11C, 15'd0, 3'b000, 3'b000, 96'd0,
               1'b1, 1'b1, F_NO, 1'b1, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,
               32'd0, 32'd0, 32'd0};

    dif.flush = 1'b0;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    drive(tbl[5]);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(dif.out_valid), 64'd0);
    chk("rst.fmt", 64'(dif.out_instr_format), 64'(F_NO));
    chk("rst.illegal", 64'(dif.out_illegal), 64'd0);
    chk("rst.pc", 64'(dif.out_pc), 64'd0);
    chk("rst.imm", 64'(dif.out_imm), 64'd0);
    chk("rst.rd", 64'(dif.out_rd), 64'd0);
    rst_n = 1'b1;

    // Table through scoreboard
    for (int unsigned n = 0; n < 9; n++) begin
      @(negedge clk);
      drive(tbl[n]);
      dif.in_valid  = 1'b1;
      dif.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d.in_ready", n), 64'(dif.in_ready), 64'(tbl[n].rdy));
      chk($sformatf("v%0d.in_ready_nofwd", n), 64'(dif0.in_ready), 64'(tbl[n].rdy_nf));
      if (tbl[n].rdy) sb.push_back(tbl[n]);
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_out($sformatf("v%0d", n), e);
      end else begin
        chk($sformatf("v%0d.bubble", n), 64'(dif.out_valid), 64'd0);
      end
    end

    // Drain, then backpressure
    @(negedge clk);
    dif.in_valid = 1'b0;
    @(negedge clk);
    drive(tbl[0]);
    dif.in_valid  = 1'b1;
    dif.out_ready = 1'b0;
    #1 chk("bp.first_ready", 64'(dif.in_ready), 64'd1);
    @(negedge clk);
    drive(tbl[5]);
    for (int unsigned c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d.in_ready", c), 64'(dif.in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.valid", c), 64'(dif.out_valid), 64'd1);
      chk($sformatf("bp%0d.pc", c), 64'(dif.out_pc), 64'h100);
      chk($sformatf("bp%0d.imm", c), 64'(dif.out_imm), 64'hFFFF_FFFF);
      @(negedge clk);
    end
    dif.out_ready = 1'b1;
    #1 chk("bp.release_ready", 64'(dif.in_ready), 64'd1);
    @(posedge clk);
    #1 check_out("bp.next", tbl[5]);

    // Flush while holding with input pending
    @(negedge clk);
    v = tbl[8];
    v.instr = 32'h0000007F;
    v.pc    = 32'h200;
    drive(v);
    dif.out_ready = 1'b0;
    dif.flush     = 1'b1;
    #1 chk("fl.in_ready", 64'(dif.in_ready), 64'd0);
    @(posedge clk);
    #1 chk("fl.valid", 64'(dif.out_valid), 64'd0);
    @(negedge clk);
    dif.flush     = 1'b0;
    dif.out_ready = 1'b1;
    #1 chk("fl.after_ready", 64'(dif.in_ready), 64'd1);
    @(posedge clk);
    #1 check_out("fl.illegal_instr", v);

    // Asynchronous reset mid-stream while output is held
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(dif.out_valid), 64'd0);
    chk("arst.fmt", 64'(dif.out_instr_format), 64'(F_NO));
    chk("arst.illegal", 64'(dif.out_illegal), 64'd0);
    chk("arst.pc", 64'(dif.out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("arst.post_valid", 64'(dif.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
